mux8_bus_bridge: RTL and testbench
==================================

Name: mux8_bus_bridge

Overview:
Parametrised bridge between the 16-bit 68k peripheral-select strobes and an 8-bit multiplexed address/data device bus (DS12887-class RTC, other muxed-bus parts).
- Supports byte and word reads and writes.
- A word access is split into two byte transactions: even address first, then odd.
- Address width and all bus phase lengths are configurable, so one block serves devices with different timing.
- Sits between the address decoder (strobes) and the FPGA pins of the device.

Parameters:
ADDR_W, 6, number of CPU word-address bits used (cpu_addr[ADDR_W:1]); device address is ADDR_W+1 bits, ADDR_W+1 <= 8.
AS_CYC, 1, clocks the as (ALE) pulse is held high; >= 1.
STB_CYC, 1, clocks rd_n/wr_n are held low; >= 1.
REC_CYC, 1, recovery clocks after each strobe with cs_n high; >= 1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_addr  in  ADDR_W  CPU address bits [ADDR_W:1]
cpu_din  in  16  CPU write data
cpu_dout  out  16  read data to CPU
rd_h_n, rd_l_n  in  1 each  upper/lower byte read strobes, active low
wr_h_n, wr_l_n  in  1 each  upper/lower byte write strobes, active low
dtack_n  out  1  data acknowledge, active low
ad  inout  8  device multiplexed address/data
as  out  1  address strobe (ALE), active high
cs_n, rd_n, wr_n  out  1 each  device chip select, read strobe, write strobe

Behaviour:
Clock and reset (already decided): reset rst_n, asynchronous, active-low; clock clk.

Reset values:
- cs_n=1, rd_n=1, wr_n=1, as=0, dtack_n=1, cpu_dout=0, internal ad_out=0, state=IDLE.
- Reset mid-transaction aborts immediately to these values.

Output registering:
- All outputs are registered.
- ad is driven from ad_out except while a read is in STROBE or its following REC, when it is tri-stated.

Byte lane mapping (big-endian):
- Upper strobe selects device address {addr,0}, data [15:8].
- Lower strobe selects device address {addr,1}, data [7:0].

Request decode (in IDLE only):
- Any read strobe low: read. Reads take priority if read and write strobes are low together.
- Otherwise any write strobe low: write.
- Both lanes active: word access. One lane active: byte access.
- On accept, latch cpu_addr, cpu_din, and the lane mask. Later changes to those inputs are ignored.

State machine (one shared phase down-counter):
- IDLE → ADDR.
- ADDR: cs_n=0, as=1, ad_out = device address, for AS_CYC clocks.
- HOLD: as=0, address still driven, 1 clock.
- STROBE: rd_n=0 or wr_n=0 for STB_CYC clocks. Writes drive the lane byte on ad_out. Reads sample ad into the lane byte of cpu_dout on the edge that ends the last STROBE clock.
- REC: rd_n=wr_n=1, cs_n=1, for REC_CYC clocks.
- After REC: if the second byte of a word is pending → ADDR at the odd address; else → DONE.
- DONE: dtack_n=0. Hold while any of the four strobes is low. When all are high → IDLE, and dtack_n=1 on the next clock.

Latency (request first seen low in IDLE at clock 0):
- Byte: dtack_n low at clock AS_CYC+STB_CYC+REC_CYC+2 (defaults: 5).
- Word: dtack_n low at clock 2*(AS_CYC+STB_CYC+REC_CYC+1)+1 (defaults: 9).

Read data: a byte read updates only its half of cpu_dout; the other half keeps its previous value.

Abort (all strobes released before DONE):
- Finish the current byte through REC so device timing is never truncated.
- Skip any pending second byte.
- Go to IDLE without asserting dtack_n.

Re-trigger: a request is never accepted outside IDLE. A held request cannot start a second transaction, because DONE waits for release.

Phase counter: width $clog2(max(AS_CYC,STB_CYC,REC_CYC)+1). It reloads on every phase entry.

Decomposition:
- Package mux8_bus_pkg: state enum (IDLE, ADDR, HOLD, STROBE, REC, DONE), default timing constants, lane-mask type.
- Sub-module mux8_phase_timer: loadable down-counter with load value, load and done flag; one instance.
- Elaboration-time assertions: all *_CYC >= 1 and ADDR_W+1 <= 8.

Test Plan:
- Byte read, rd_l_n low, cpu_addr=6'h05, device returns 8'h3C → ad shows 8'h0B during as; dtack_n low at clock 5; cpu_dout[7:0]=8'h3C, upper byte unchanged.
- Word read, both read strobes low, cpu_addr=6'h02, device returns 8'h12 at 8'h04 and 8'h34 at 8'h05 → two as pulses, even address first; cpu_dout=16'h1234; dtack_n low at clock 9.
- Word write, cpu_din=16'hA55A, cpu_addr=6'h00 → 8'hA5 written to address 0, then 8'h5A to address 1; wr_n low 1 clock each; ad driven throughout.
- Parameters AS_CYC=2, STB_CYC=3, REC_CYC=2, byte write → as high 2 clocks, wr_n low 3 clocks, cs_n high 2 clocks; dtack_n low at clock 9.
- Strobes released during the first STROBE of a word read → REC completes, no second as pulse, dtack_n stays 1, back in IDLE; the next request is served normally.
- rst_n pulsed low during STROBE of a write → wr_n, cs_n and dtack_n go high and as goes 0 asynchronously; no further bus activity until a new request.

Source files
------------

// File: rtl/mux8_bus_pkg.sv
// rtl/mux8_bus_pkg.sv - shared types and defaults for the 8-bit muxed-bus bridge
package mux8_bus_pkg;

    // Bus sequencer states, one per device bus phase
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HOLD,
        STROBE,
        REC,
        DONE
    } state_t;

    // Default timing, one clock per phase
    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_AS_CYC  = 1;
    localparam int DEF_STB_CYC = 1;
    localparam int DEF_REC_CYC = 1;

    // Byte lanes requested by the CPU: hi = D15..D8 (even address), lo = D7..D0 (odd)
    typedef struct packed {
        logic hi;
        logic lo;
    } lane_mask_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mux8_phase_timer.sv
// rtl/mux8_phase_timer.sv - loadable down-counter timing each bus phase
module mux8_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mux8_bus_bridge.sv
// rtl/mux8_bus_bridge.sv - 68k byte/word strobes to 8-bit muxed address/data bus bridge
module mux8_bus_bridge
    import mux8_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int AS_CYC  = DEF_AS_CYC,
    parameter int STB_CYC = DEF_STB_CYC,
    parameter int REC_CYC = DEF_REC_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    input  logic              rd_h_n,
    input  logic              rd_l_n,
    input  logic              wr_h_n,
    input  logic              wr_l_n,
    output logic              dtack_n,
    inout  wire  [7:0]        ad,
    output logic              as,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n
);

    localparam int MAX_CYC = max3(AS_CYC, STB_CYC, REC_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] AS_LD  = CNT_W'(AS_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LD = CNT_W'(STB_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LD = CNT_W'(REC_CYC - 1);

    if (AS_CYC < 1 || STB_CYC < 1 || REC_CYC < 1) begin : g_bad_cyc
        $error("mux8_bus_bridge: every phase length must be at least one clock");
    end
    if (ADDR_W + 1 > 8) begin : g_bad_addr
        $error("mux8_bus_bridge: device address must fit the 8-bit ad bus");
    end

    state_t              state_q, state_d;
    logic                tmr_load, tmr_done;
    logic [CNT_W-1:0]    tmr_val;
    logic                accept, next_byte, sample_rd, sample_q;
    logic                is_rd_q, cur_low_q, second_q, abort_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         din_q;
    logic [7:0]          ad_out;
    logic                ad_oe;
    logic                rd_req, wr_req, all_idle;
    lane_mask_t          req_lanes;
    logic [7:0]          dev_addr, wr_byte;

    assign rd_req    = !rd_h_n || !rd_l_n;
    assign wr_req    = !wr_h_n || !wr_l_n;
    assign all_idle  = rd_h_n && rd_l_n && wr_h_n && wr_l_n;
    assign req_lanes = rd_req ? lane_mask_t'({!rd_h_n, !rd_l_n})
                              : lane_mask_t'({!wr_h_n, !wr_l_n});
    assign dev_addr  = 8'({addr_q, cur_low_q});
    assign wr_byte   = cur_low_q ? din_q[7:0] : din_q[15:8];
    assign ad        = ad_oe ? ad_out : 8'bz;

    mux8_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and phase-timer control
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        accept    = 1'b0;
        next_byte = 1'b0;
        sample_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    accept   = 1'b1;
                    state_d  = ADDR;
                    tmr_load = 1'b1;
                    tmr_val  = AS_LD;
                end
            end
            ADDR: begin
                if (tmr_done) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                end
            end
            HOLD: begin
                state_d  = STROBE;
                tmr_load = 1'b1;
                tmr_val  = STB_LD;
            end
            STROBE: begin
                if (tmr_done) begin
                    state_d   = REC;
                    tmr_load  = 1'b1;
                    tmr_val   = REC_LD;
                    sample_rd = is_rd_q;
                end
            end
            REC: begin
                if (tmr_done) begin
                    if (abort_q || all_idle) begin
                        state_d = IDLE;
                    end else if (second_q) begin
                        state_d   = ADDR;
                        tmr_load  = 1'b1;
                        tmr_val   = AS_LD;
                        next_byte = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (all_idle) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latching, lane sequencing, abort tracking and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rd_q   <= 1'b0;
            cur_low_q <= 1'b0;
            second_q  <= 1'b0;
            abort_q   <= 1'b0;
            sample_q  <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            cpu_dout  <= '0;
        end else begin
            sample_q <= sample_rd;
            if (accept) begin
                is_rd_q   <= rd_req;
                addr_q    <= cpu_addr;
                din_q     <= cpu_din;
                cur_low_q <= !req_lanes.hi;
                second_q  <= req_lanes.hi && req_lanes.lo;
                abort_q   <= 1'b0;
            end else if (all_idle && state_q inside {ADDR, HOLD, STROBE, REC}) begin
                abort_q <= 1'b1;
            end
            if (next_byte) begin
                cur_low_q <= 1'b1;
                second_q  <= 1'b0;
            end
            // rd_n is still low here: this edge ends the last strobe clock seen by the device
            if (sample_q) begin
                if (cur_low_q) begin
                    cpu_dout[7:0] <= ad;
                end else begin
                    cpu_dout[15:8] <= ad;
                end
            end
        end
    end

    // Registered bus pins, derived from the phase the sequencer is in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n    <= 1'b1;
            as      <= 1'b0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            dtack_n <= 1'b1;
            ad_out  <= '0;
            ad_oe   <= 1'b1;
        end else begin
            cs_n    <= !(state_q inside {ADDR, HOLD, STROBE});
            as      <= (state_q == ADDR);
            rd_n    <= !(state_q == STROBE && is_rd_q);
            wr_n    <= !(state_q == STROBE && !is_rd_q);
            dtack_n <= (state_q != DONE);
            ad_oe   <= !(is_rd_q && (state_q == STROBE || state_q == REC));
            if (state_q == ADDR || state_q == HOLD) begin
                ad_out <= dev_addr;
            end else if (state_q == STROBE && !is_rd_q) begin
                ad_out <= wr_byte;
            end
        end
    end

endmodule

// File: tb/tb_mux8_bus_bridge.sv
// tb/tb_mux8_bus_bridge.sv - self-checking bench for mux8_bus_bridge
module tb_mux8_bus_bridge;

    typedef logic [16:0] ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  cpu_addr, cpu_addr2;
    logic [15:0] cpu_din, cpu_din2, cpu_dout, cpu_dout2;
    logic        rd_h_n, rd_l_n, wr_h_n, wr_l_n;
    logic        rd_h2_n, rd_l2_n, wr_h2_n, wr_l2_n;
    logic        dtack_n, as, cs_n, rd_n, wr_n;
    logic        dtack2_n, as2, cs2_n, rd2_n, wr2_n;
    wire  [7:0]  ad, ad2;

    logic [7:0]  dev_mem [256];
    logic [7:0]  lat_addr = 8'h00;
    logic        as_prev = 1'b0, rd_prev = 1'b1, wr_prev = 1'b1;
    int          as_pulses = 0, wr_lo_cnt = 0, dtack_cnt = 0, adx_cnt = 0, obs_cnt = 0;
    ev_t         obs_log [64];
    ev_t         exp_q [$];
    int          rd_ptr = 0;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mux8_bus_bridge dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .rd_h_n(rd_h_n), .rd_l_n(rd_l_n), .wr_h_n(wr_h_n), .wr_l_n(wr_l_n), .dtack_n(dtack_n),
        .ad(ad), .as(as), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    mux8_bus_bridge #(.ADDR_W(6), .AS_CYC(2), .STB_CYC(3), .REC_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr2), .cpu_din(cpu_din2), .cpu_dout(cpu_dout2),
        .rd_h_n(rd_h2_n), .rd_l_n(rd_l2_n), .wr_h_n(wr_h2_n), .wr_l_n(wr_l2_n), .dtack_n(dtack2_n),
        .ad(ad2), .as(as2), .cs_n(cs2_n), .rd_n(rd2_n), .wr_n(wr2_n)
    );

    // Device model: returns the byte at the latched address while selected and read-strobed
    assign ad = (!cs_n && !rd_n) ? dev_mem[lat_addr] : 8'bz;

    // Bus monitor: latches address on as, logs each strobe as {is_write, addr, data}
    always @(negedge clk) begin
        if (as && !as_prev) begin
            lat_addr  <= ad;
            as_pulses <= as_pulses + 1;
        end
        if (!wr_n && wr_prev && obs_cnt < 64) begin
            obs_log[obs_cnt] <= {1'b1, lat_addr, ad};
            obs_cnt <= obs_cnt + 1;
        end else if (!rd_n && rd_prev && obs_cnt < 64) begin
            obs_log[obs_cnt] <= {1'b0, lat_addr, ad};
            obs_cnt <= obs_cnt + 1;
        end
        if (!wr_n) wr_lo_cnt <= wr_lo_cnt + 1;
        if (!dtack_n) dtack_cnt <= dtack_cnt + 1;
        if (!cs_n && $isunknown(ad)) adx_cnt <= adx_cnt + 1;
        as_prev <= as;
        rd_prev <= rd_n;
        wr_prev <= wr_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        ev_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_ptr < obs_cnt) begin
                o = obs_log[rd_ptr];
                rd_ptr++;
            end else begin
                o = 'x;
            end
            chk({tag, "_event"}, 32'(o), 32'(e));
        end
        chk({tag, "_no_extra_events"}, obs_cnt, rd_ptr);
    endtask

    // One complete CPU cycle: assert strobes, measure dtack latency, release, check dtack returns high
    task automatic do_req(input string tag, input logic rh, input logic rl, input logic wh,
                          input logic wl, input logic [5:0] a, input logic [15:0] d,
                          input int exp_lat);
        int lat;
        @(negedge clk);
        cpu_addr = a;
        cpu_din  = d;
        rd_h_n = !rh; rd_l_n = !rl; wr_h_n = !wh; wr_l_n = !wl;
        @(posedge clk);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!dtack_n) begin
                lat = c;
                break;
            end
            @(posedge clk);
        end
        chk({tag, "_dtack_latency"}, lat, exp_lat);
        rd_h_n = 1'b1; rd_l_n = 1'b1; wr_h_n = 1'b1; wr_l_n = 1'b1;
        cpu_din = 16'hxxxx;
        repeat (3) @(negedge clk);
        chk({tag, "_dtack_released"}, dtack_n, 1'b1);
    endtask

    initial begin
        int as0, wr0, dt0, ax0, found;
        int lat2, as_hi, wr_lo, cs_rec, wr_seen;
        logic [7:0] addr2, wdata2;

        rst_n = 1'b0;
        cpu_addr = '0; cpu_din = '0; cpu_addr2 = '0; cpu_din2 = '0;
        rd_h_n = 1'b1; rd_l_n = 1'b1; wr_h_n = 1'b1; wr_l_n = 1'b1;
        rd_h2_n = 1'b1; rd_l2_n = 1'b1; wr_h2_n = 1'b1; wr_l2_n = 1'b1;
        for (int i = 0; i < 256; i++) dev_mem[i] = 8'hFF;
        dev_mem[8'h0B] = 8'h3C;
        dev_mem[8'h04] = 8'h12;
        dev_mem[8'h05] = 8'h34;
        dev_mem[8'h0E] = 8'h9E;
        dev_mem[8'h10] = 8'h77;
        dev_mem[8'h11] = 8'h88;

        repeat (3) @(negedge clk);
        chk("rst_outputs", {cs_n, rd_n, wr_n, as, dtack_n}, 5'b11101);
        chk("rst_cpu_dout", cpu_dout, 16'h0000);
        chk("rst_ad", ad, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Byte read, lower lane
        exp_q.push_back({1'b0, 8'h0B, 8'h3C});
        do_req("byte_rd", 1'b0, 1'b1, 1'b0, 1'b0, 6'h05, 16'h0000, 5);
        chk("byte_rd_dout", cpu_dout, 16'h003C);
        sb_check("byte_rd");

        // Word read, even byte first
        as0 = as_pulses;
        exp_q.push_back({1'b0, 8'h04, 8'h12});
        exp_q.push_back({1'b0, 8'h05, 8'h34});
        do_req("word_rd", 1'b1, 1'b1, 1'b0, 1'b0, 6'h02, 16'h0000, 9);
        chk("word_rd_dout", cpu_dout, 16'h1234);
        chk("word_rd_as_pulses", as_pulses - as0, 2);
        sb_check("word_rd");

        // Byte read, upper lane only updates D15..D8
        exp_q.push_back({1'b0, 8'h0E, 8'h9E});
        do_req("upper_rd", 1'b1, 1'b0, 1'b0, 1'b0, 6'h07, 16'h0000, 5);
        chk("upper_rd_dout", cpu_dout, 16'h9E34);
        sb_check("upper_rd");

        // Word write
        wr0 = wr_lo_cnt;
        ax0 = adx_cnt;
        exp_q.push_back({1'b1, 8'h00, 8'hA5});
        exp_q.push_back({1'b1, 8'h01, 8'h5A});
        do_req("word_wr", 1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 16'hA55A, 9);
        chk("word_wr_wr_low_clocks", wr_lo_cnt - wr0, 2);
        chk("word_wr_ad_driven", adx_cnt - ax0, 0);
        sb_check("word_wr");

        // Abort during first strobe of a word read
        as0 = as_pulses;
        dt0 = dtack_cnt;
        @(negedge clk);
        cpu_addr = 6'h08;
        rd_h_n = 1'b0; rd_l_n = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!rd_n) begin
                found = 1;
                break;
            end
        end
        rd_h_n = 1'b1; rd_l_n = 1'b1;
        chk("abort_strobe_seen", found, 1);
        repeat (12) @(negedge clk);
        chk("abort_as_pulses", as_pulses - as0, 1);
        chk("abort_no_dtack", dtack_cnt - dt0, 0);
        chk("abort_idle_cs", cs_n, 1'b1);
        chk("abort_dout", cpu_dout, 16'h7734);
        exp_q.push_back({1'b0, 8'h10, 8'h77});
        sb_check("abort");

        // Next request after abort is served normally
        exp_q.push_back({1'b0, 8'h11, 8'h88});
        do_req("post_abort", 1'b0, 1'b1, 1'b0, 1'b0, 6'h08, 16'h0000, 5);
        chk("post_abort_dout", cpu_dout, 16'h7788);
        sb_check("post_abort");

        // Asynchronous reset during a write strobe
        @(negedge clk);
        cpu_addr = 6'h0A;
        cpu_din  = 16'hBEEF;
        wr_h_n   = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!wr_n) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid_strobe_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {cs_n, rd_n, wr_n, as, dtack_n}, 5'b11101);
        wr_h_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        as0 = as_pulses;
        dt0 = dtack_cnt;
        repeat (8) @(negedge clk);
        chk("rst_mid_no_activity", as_pulses - as0, 0);
        chk("rst_mid_no_dtack", dtack_cnt - dt0, 0);
        chk("rst_mid_cs", cs_n, 1'b1);
        chk("rst_mid_dout", cpu_dout, 16'h0000);
        exp_q.push_back({1'b1, 8'h14, 8'hBE});
        sb_check("rst_mid");

        exp_q.push_back({1'b1, 8'h07, 8'h55});
        do_req("post_rst_wr", 1'b0, 1'b0, 1'b0, 1'b1, 6'h03, 16'h0055, 5);
        sb_check("post_rst_wr");

        // Stretched timing instance: byte write, lower lane
        @(negedge clk);
        cpu_addr2 = 6'h11;
        cpu_din2  = 16'h00C3;
        wr_l2_n   = 1'b0;
        @(posedge clk);
        lat2 = -1; as_hi = 0; wr_lo = 0; cs_rec = 0; wr_seen = 0;
        addr2 = 8'h00; wdata2 = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (as2) begin
                if (as_hi == 0) addr2 = ad2;
                as_hi++;
            end
            if (!wr2_n) begin
                if (wr_seen == 0) wdata2 = ad2;
                wr_seen = 1;
                wr_lo++;
            end else if (wr_seen != 0 && cs2_n && dtack2_n) begin
                cs_rec++;
            end
            if (!dtack2_n) begin
                lat2 = c;
                break;
            end
            @(posedge clk);
        end
        wr_l2_n = 1'b1;
        chk("slow_dtack_latency", lat2, 9);
        chk("slow_as_clocks", as_hi, 2);
        chk("slow_wr_clocks", wr_lo, 3);
        chk("slow_rec_clocks", cs_rec, 2);
        chk("slow_addr", addr2, 8'h23);
        chk("slow_wdata", wdata2, 8'hC3);
        repeat (3) @(negedge clk);
        chk("slow_dtack_released", dtack2_n, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
